// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command sequencer: opcodes, FSM state
// encodings and the register-file locations of the ALU operands.
package uart_cmd_pkg;

  // Opcodes recognised as the first byte of a command
  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  // Sequencer states
  typedef logic [3:0] state_t;
  localparam state_t IDLE     = 4'd0;
  localparam state_t WR_ADDR  = 4'd1;
  localparam state_t WR_DATA  = 4'd2;
  localparam state_t RD_ADDR  = 4'd3;
  localparam state_t RD_WAIT  = 4'd4;
  localparam state_t ALU_A    = 4'd5;
  localparam state_t ALU_B    = 4'd6;
  localparam state_t ALU_FN   = 4'd7;
  localparam state_t ALU_WAIT = 4'd8;
  localparam state_t TX_RD    = 4'd9;
  localparam state_t TX_LO    = 4'd10;
  localparam state_t TX_HI    = 4'd11;

  // Register-file slots that hold the ALU operands
  localparam int OPA_ADDR = 0;
  localparam int OPB_ADDR = 1;

  // First state of a command given its opcode byte; unknown bytes keep IDLE
  function automatic state_t opcodeToState(input logic [7:0] opcode);
    case (opcode)
      CMD_WR:      return WR_ADDR;
      CMD_RD:      return RD_ADDR;
      CMD_ALU_OP:  return ALU_A;
      CMD_ALU_NOP: return ALU_FN;
      default:     return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Bundle of every data/handshake signal between the command sequencer and
// the UART datapath, register file and ALU. The sequencer is the master.
interface uart_cmd_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
);

  logic [DATA_WIDTH-1:0]   RX_P_DATA;
  logic                    RX_D_VLD;
  logic [DATA_WIDTH-1:0]   RdData;
  logic                    RdData_Valid;
  logic [2*DATA_WIDTH-1:0] ALU_OUT;
  logic                    ALU_OUT_VLD;
  logic                    TX_RDY;
  logic                    WrEn;
  logic                    RdEn;
  logic [ADDR_WIDTH-1:0]   Address;
  logic [DATA_WIDTH-1:0]   WrData;
  logic                    ALU_EN;
  logic [FUN_WIDTH-1:0]    ALU_FUN;
  logic                    CLK_EN;
  logic [DATA_WIDTH-1:0]   TX_P_DATA;
  logic                    TX_D_VLD;

  modport master (
    input  RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, ALU_OUT_VLD, TX_RDY,
    output WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_EN, TX_P_DATA, TX_D_VLD
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, ALU_OUT_VLD, TX_RDY,
    input  WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_EN, TX_P_DATA, TX_D_VLD
  );

endinterface

// File: rtl/uart_tx_byte_sender.sv
// Holds one byte towards the UART transmitter with a valid/ready handshake.
// done_o marks the cycle in which the held byte is accepted; a new byte may
// be loaded in that same cycle so consecutive bytes go out without a gap.
module uart_tx_byte_sender #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] byte_i,
  input  logic                  txRdy_i,
  output logic [DATA_WIDTH-1:0] txData_o,
  output logic                  txVld_o,
  output logic                  done_o
);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  vld_q, vld_d;

  // Drop valid on acceptance unless a fresh byte is loaded in the same cycle
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (vld_q && txRdy_i) begin
      vld_d = 1'b0;
    end
    if (load_i) begin
      data_d = byte_i;
      vld_d  = 1'b1;
    end
  end

  // Byte and valid registers, cleared by synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign txData_o = data_q;
  assign txVld_o  = vld_q;
  assign done_o   = vld_q & txRdy_i;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Command sequencer: parses opcode/operand bytes from the UART receiver,
// issues register-file writes/reads and ALU operations, and returns read
// data or the 16-bit ALU result to the transmitter. All strobes are
// registered, so a new byte can be accepted in the cycle a strobe is high.
// The parameters must match those of the connected interface instance.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
) (
  input logic               CLK,
  input logic               RST,
  uart_cmd_ctrl_if.master   bus
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic [DATA_WIDTH-1:0] wrData_q, wrData_d;
  logic                  wrEn_q, wrEn_d;
  logic                  rdEn_q, rdEn_d;
  logic                  aluEn_q, aluEn_d;
  logic                  clkEn_q, clkEn_d;
  logic [FUN_WIDTH-1:0]  aluFun_q, aluFun_d;
  logic [DATA_WIDTH-1:0] resultHi_q, resultHi_d;

  logic                  txLoad;
  logic [DATA_WIDTH-1:0] txByte;
  logic                  txDone;
  logic [DATA_WIDTH-1:0] txData;
  logic                  txVld;

  // Next-state and output decode; write/read strobes default low so each is a single-cycle pulse
  always_comb begin
    state_d    = state_q;
    address_d  = address_q;
    wrData_d   = wrData_q;
    wrEn_d     = 1'b0;
    rdEn_d     = 1'b0;
    aluEn_d    = aluEn_q;
    clkEn_d    = clkEn_q;
    aluFun_d   = aluFun_q;
    resultHi_d = resultHi_q;
    txLoad     = 1'b0;
    txByte     = '0;

    case (state_q)
      IDLE: begin
        if (bus.RX_D_VLD) begin
          state_d = opcodeToState(8'(bus.RX_P_DATA));
        end
      end

      WR_ADDR: begin
        if (bus.RX_D_VLD) begin
          address_d = bus.RX_P_DATA[ADDR_WIDTH-1:0];
          state_d   = WR_DATA;
        end
      end

      WR_DATA: begin
        if (bus.RX_D_VLD) begin
          wrEn_d   = 1'b1;
          wrData_d = bus.RX_P_DATA;
          state_d  = IDLE;
        end
      end

      RD_ADDR: begin
        if (bus.RX_D_VLD) begin
          address_d = bus.RX_P_DATA[ADDR_WIDTH-1:0];
          rdEn_d    = 1'b1;
          state_d   = RD_WAIT;
        end
      end

      RD_WAIT: begin
        if (bus.RdData_Valid) begin
          txLoad  = 1'b1;
          txByte  = bus.RdData;
          state_d = TX_RD;
        end
      end

      TX_RD: begin
        if (txDone) begin
          state_d = IDLE;
        end
      end

      ALU_A: begin
        if (bus.RX_D_VLD) begin
          wrEn_d    = 1'b1;
          address_d = ADDR_WIDTH'(OPA_ADDR);
          wrData_d  = bus.RX_P_DATA;
          state_d   = ALU_B;
        end
      end

      ALU_B: begin
        if (bus.RX_D_VLD) begin
          wrEn_d    = 1'b1;
          address_d = ADDR_WIDTH'(OPB_ADDR);
          wrData_d  = bus.RX_P_DATA;
          state_d   = ALU_FN;
        end
      end

      ALU_FN: begin
        if (bus.RX_D_VLD) begin
          aluFun_d = bus.RX_P_DATA[FUN_WIDTH-1:0];
          aluEn_d  = 1'b1;
          clkEn_d  = 1'b1;
          state_d  = ALU_WAIT;
        end
      end

      ALU_WAIT: begin
        if (bus.ALU_OUT_VLD) begin
          aluEn_d    = 1'b0;
          clkEn_d    = 1'b0;
          resultHi_d = bus.ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH];
          txLoad     = 1'b1;
          txByte     = bus.ALU_OUT[DATA_WIDTH-1:0];
          state_d    = TX_LO;
        end
      end

      TX_LO: begin
        if (txDone) begin
          txLoad  = 1'b1;
          txByte  = resultHi_q;
          state_d = TX_HI;
        end
      end

      TX_HI: begin
        if (txDone) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any command in flight
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      address_q  <= '0;
      wrData_q   <= '0;
      wrEn_q     <= 1'b0;
      rdEn_q     <= 1'b0;
      aluEn_q    <= 1'b0;
      clkEn_q    <= 1'b0;
      aluFun_q   <= '0;
      resultHi_q <= '0;
    end else begin
      state_q    <= state_d;
      address_q  <= address_d;
      wrData_q   <= wrData_d;
      wrEn_q     <= wrEn_d;
      rdEn_q     <= rdEn_d;
      aluEn_q    <= aluEn_d;
      clkEn_q    <= clkEn_d;
      aluFun_q   <= aluFun_d;
      resultHi_q <= resultHi_d;
    end
  end

  uart_tx_byte_sender #(
    .DATA_WIDTH(DATA_WIDTH)
  ) txSender (
    .clk_i    (CLK),
    .rst_i    (RST),
    .load_i   (txLoad),
    .byte_i   (txByte),
    .txRdy_i  (bus.TX_RDY),
    .txData_o (txData),
    .txVld_o  (txVld),
    .done_o   (txDone)
  );

  assign bus.WrEn      = wrEn_q;
  assign bus.RdEn      = rdEn_q;
  assign bus.Address   = address_q;
  assign bus.WrData    = wrData_q;
  assign bus.ALU_EN    = aluEn_q;
  assign bus.ALU_FUN   = aluFun_q;
  assign bus.CLK_EN    = clkEn_q;
  assign bus.TX_P_DATA = txData;
  assign bus.TX_D_VLD  = txVld;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: directed command scenarios followed by random
// commands. Each command pushes the register writes, reads, ALU functions
// and transmit bytes it should cause into queues; a monitor on the falling
// edge pops them as the DUT produces them.
module tb_uart_cmd_ctrl;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  always #5 CLK = ~CLK;

  uart_cmd_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4)) bus ();

  uart_cmd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int checkCount = 0;
  int passCount  = 0;
  int txCount    = 0;

  logic [7:0] expWrAddr[$];
  logic [7:0] expWrData[$];
  logic [7:0] expRdAddr[$];
  logic [7:0] expFun[$];
  logic [7:0] expTx[$];

  bit         rdyRandom = 1'b0;
  bit         prevStall = 1'b0;
  bit         prevAluEn = 1'b0;
  logic [7:0] prevData  = 8'h00;
  logic [7:0] monA, monD;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected)
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    else
      passCount++;
  endtask

  function automatic logic [31:0] outVec();
    return 32'({bus.WrEn, bus.RdEn, bus.Address, bus.WrData, bus.ALU_EN,
                bus.ALU_FUN, bus.CLK_EN, bus.TX_D_VLD, bus.TX_P_DATA});
  endfunction

  // Monitor: matches strobes and transmitted bytes against the expectation queues
  always @(negedge CLK) begin
    if (bus.WrEn === 1'b1 || bus.RdEn === 1'b1)
      checkOutput("wrRdExclusive", 32'(bus.WrEn & bus.RdEn), 32'd0);
    if (bus.WrEn === 1'b1) begin
      if (expWrAddr.size() == 0) checkOutput("wrUnexpected", 32'(bus.WrEn), 32'd0);
      else begin
        monA = expWrAddr.pop_front();
        monD = expWrData.pop_front();
        checkOutput("wrAddress", 32'(bus.Address), 32'(monA));
        checkOutput("wrData", 32'(bus.WrData), 32'(monD));
      end
    end
    if (bus.RdEn === 1'b1) begin
      if (expRdAddr.size() == 0) checkOutput("rdUnexpected", 32'(bus.RdEn), 32'd0);
      else begin
        monA = expRdAddr.pop_front();
        checkOutput("rdAddress", 32'(bus.Address), 32'(monA));
      end
    end
    if (bus.ALU_EN === 1'b1 && !prevAluEn) begin
      if (expFun.size() == 0) checkOutput("aluUnexpected", 32'(bus.ALU_EN), 32'd0);
      else begin
        monA = expFun.pop_front();
        checkOutput("aluFun", 32'(bus.ALU_FUN), 32'(monA));
      end
    end
    prevAluEn = (bus.ALU_EN === 1'b1);
    if (bus.ALU_EN === 1'b1 || bus.CLK_EN === 1'b1)
      checkOutput("clkEnWithAluEn", 32'(bus.CLK_EN), 32'(bus.ALU_EN));
    if (prevStall)
      checkOutput("txHold", 32'({bus.TX_D_VLD, bus.TX_P_DATA}), 32'({1'b1, prevData}));
    if (bus.TX_D_VLD === 1'b1 && bus.TX_RDY === 1'b1) begin
      txCount++;
      if (expTx.size() == 0) checkOutput("txUnexpected", 32'(bus.TX_D_VLD), 32'd0);
      else begin
        monD = expTx.pop_front();
        checkOutput("txByte", 32'(bus.TX_P_DATA), 32'(monD));
      end
    end
    prevStall = (bus.TX_D_VLD === 1'b1 && bus.TX_RDY !== 1'b1);
    prevData  = bus.TX_P_DATA;
  end

  // Advance one cycle and land 1 time unit after the rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
    if (rdyRandom) bus.TX_RDY = ($urandom_range(0, 1) == 1);
  endtask

  task automatic sendByte(input logic [7:0] b);
    bus.RX_P_DATA = b;
    bus.RX_D_VLD  = 1'b1;
    tick();
    bus.RX_D_VLD  = 1'b0;
  endtask

  task automatic doWrite(input logic [7:0] a, input logic [7:0] d);
    expWrAddr.push_back(a % 8'd16);
    expWrData.push_back(d);
    sendByte(8'hAA);
    sendByte(a);
    sendByte(d);
    checkOutput("wrLatency", 32'(bus.WrEn), 32'd1);
  endtask

  task automatic doRead(input logic [7:0] a, input logic [7:0] d, input int lat,
                        input logic [7:0] junk, input bit useJunk);
    expRdAddr.push_back(a % 8'd16);
    expTx.push_back(d);
    sendByte(8'hBB);
    sendByte(a);
    checkOutput("rdLatency", 32'(bus.RdEn), 32'd1);
    for (int i = 0; i < lat; i++) begin
      if (i == 0 && useJunk) sendByte(junk);
      else tick();
    end
    bus.RdData       = d;
    bus.RdData_Valid = 1'b1;
    tick();
    bus.RdData_Valid = 1'b0;
    checkOutput("txAfterRead", 32'({bus.TX_D_VLD, bus.TX_P_DATA}), 32'({1'b1, d}));
  endtask

  task automatic doAlu(input bit withOps, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] fun, input logic [15:0] r, input int lat,
                       input logic [7:0] junk, input bit useJunk);
    logic [3:0] funLow;
    funLow = 4'(fun % 8'd16);
    if (withOps) begin
      expWrAddr.push_back(8'd0); expWrData.push_back(a);
      expWrAddr.push_back(8'd1); expWrData.push_back(b);
    end
    expFun.push_back(8'(funLow));
    expTx.push_back(8'(r % 16'd256));
    expTx.push_back(8'(r / 16'd256));
    if (withOps) begin
      sendByte(8'hCC);
      sendByte(a);
      checkOutput("opALatency", 32'(bus.WrEn), 32'd1);
      sendByte(b);
      checkOutput("opBLatency", 32'(bus.WrEn), 32'd1);
    end else begin
      sendByte(8'hDD);
    end
    sendByte(fun);
    checkOutput("aluLatency", 32'({bus.ALU_EN, bus.CLK_EN}), 32'd3);
    for (int i = 0; i < lat; i++) begin
      checkOutput("aluHold", 32'({bus.ALU_EN, bus.CLK_EN, bus.ALU_FUN}), 32'({2'b11, funLow}));
      if (i == 0 && useJunk) sendByte(junk);
      else tick();
    end
    bus.ALU_OUT     = r;
    bus.ALU_OUT_VLD = 1'b1;
    tick();
    bus.ALU_OUT_VLD = 1'b0;
    checkOutput("aluRelease", 32'({bus.ALU_EN, bus.CLK_EN}), 32'd0);
  endtask

  // Wait until every expected event has been seen and the transmitter is idle
  task automatic waitIdle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (expWrAddr.size() == 0 && expRdAddr.size() == 0 && expFun.size() == 0 &&
          expTx.size() == 0 && bus.TX_D_VLD !== 1'b1)
        done = 1'b1;
      else
        tick();
    end
    checkOutput("cmdDone", 32'(done), 32'd1);
  endtask

  task automatic applyStimulus();
    int         txStart;
    int         kind;
    logic [7:0] b;

    bus.RX_P_DATA = 8'h00; bus.RX_D_VLD = 1'b0;
    bus.RdData = 8'h00; bus.RdData_Valid = 1'b0;
    bus.ALU_OUT = 16'h0000; bus.ALU_OUT_VLD = 1'b0;
    bus.TX_RDY = 1'b1;
    RST = 1'b1;
    tick();
    tick();
    checkOutput("resetOutputs", outVec(), 32'd0);
    RST = 1'b0;

    // Two writes back to back, second opcode arriving during the first WrEn
    doWrite(8'h05, 8'h3C);
    doWrite(8'h0A, 8'h77);
    waitIdle();

    // Read with the transmitter stalled for four cycles
    bus.TX_RDY = 1'b0;
    txStart = txCount;
    doRead(8'h07, 8'h5A, 2, 8'h00, 1'b0);
    repeat (3) tick();
    checkOutput("txStalled", 32'({bus.TX_D_VLD, bus.TX_P_DATA}), 32'h15A);
    bus.TX_RDY = 1'b1;
    tick();
    checkOutput("rdOneTransfer", 32'(txCount - txStart), 32'd1);
    checkOutput("txReleased", 32'(bus.TX_D_VLD), 32'd0);
    waitIdle();

    // ALU with operands, then without operands while a byte is dropped in the wait
    doAlu(1'b1, 8'h12, 8'h34, 8'h00, 16'h0046, 2, 8'h00, 1'b0);
    waitIdle();
    rdyRandom = 1'b1;
    doAlu(1'b0, 8'h00, 8'h00, 8'h02, 16'($urandom_range(0, 65535)), 3, 8'hAA, 1'b1);
    waitIdle();

    // Unknown opcode is ignored
    sendByte(8'h55);
    doWrite(8'h01, 8'hFF);
    waitIdle();

    // Reset while the second operand is awaited
    expWrAddr.push_back(8'd0);
    expWrData.push_back(8'h12);
    sendByte(8'hCC);
    sendByte(8'h12);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checkOutput("midCmdReset", outVec(), 32'd0);
    doRead(8'h03, 8'($urandom_range(0, 255)), 1, 8'h00, 1'b0);
    waitIdle();

    // Random command mix, including out-of-range addresses and dropped bytes
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0: doWrite(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        1: doRead(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), $urandom_range(0, 4),
                  8'($urandom_range(0, 255)), $urandom_range(0, 1) == 1);
        2: doAlu(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 16'($urandom_range(0, 65535)), $urandom_range(1, 4), 8'($urandom_range(0, 255)),
                 $urandom_range(0, 1) == 1);
        3: doAlu(1'b0, 8'h00, 8'h00, 8'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)),
                 $urandom_range(1, 4), 8'($urandom_range(0, 255)), $urandom_range(0, 1) == 1);
        default: begin
          b = 8'($urandom_range(0, 255));
          while (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD) b = 8'($urandom_range(0, 255));
          sendByte(b);
        end
      endcase
      waitIdle();
    end
  endtask

  initial begin
    applyStimulus();
    repeat (3) tick();
    checkOutput("leftoverExpectations",
                32'(expWrAddr.size() + expRdAddr.size() + expFun.size() + expTx.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  // Guard against a hang anywhere in the run
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached, observed no finish, expected finish");
    $display("%0d/%0d checks passed", passCount, checkCount + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
